// File: rtl/bcd_time_counter.sv
// Centisecond time base plus 8-digit packed-BCD HH.MM.SS.cc up/down counter.
// Each BCD byte is advanced by one bcd_field instance; carries/borrows ripple cc -> hh.

module bcd_field #(
  parameter logic [7:0] MAX = 8'h99
) (
  input  logic [7:0] val,
  input  logic       down,
  input  logic       en,
  output logic [7:0] nxt
);
  always_comb begin
    nxt = val;
    if (en) begin
      if (!down) begin
        if (val == MAX)             nxt = 8'h00;
        else if (val[3:0] == 4'd9)  nxt = {val[7:4] + 4'd1, 4'd0};
        else                        nxt = {val[7:4], val[3:0] + 4'd1};
      end else begin
        if (val == 8'h00)           nxt = MAX;
        else if (val[3:0] == 4'd0)  nxt = {val[7:4] - 4'd1, 4'd9};
        else                        nxt = {val[7:4], val[3:0] - 4'd1};
      end
    end
  end
endmodule

module bcd_time_counter #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        load,
  input  logic        dir,
  input  logic [31:0] preset_data,
  output logic [31:0] time_data,
  output logic        running,
  output logic        expired,
  output logic        tick
);
  localparam int NUM_FIELDS = 4;
  localparam int DIV        = CLK_FREQ / TICK_HZ;
  localparam int PW         = $clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t  state;
  logic [PW-1:0] presc;
  logic    dir_q;

  logic [NUM_FIELDS-1:0][7:0] cur, cnt_nxt;
  logic [NUM_FIELDS-1:0]      carry;
  logic preset_ok, at_zero, fire;

  assign cur      = time_data;
  assign carry[0] = 1'b1;
  assign at_zero  = (time_data == 32'h0);
  assign fire     = (state == RUN) && (presc == PMAX);

  // Minute and second tens are capped at 5; every other nibble is plain decimal.
  always_comb begin
    preset_ok = (preset_data[23:20] <= 4'd5) && (preset_data[15:12] <= 4'd5);
    for (int n = 0; n < 8; n++)
      if (preset_data[n*4 +: 4] > 4'd9) preset_ok = 1'b0;
  end

  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_fld
    localparam logic [7:0] LMAX = (i == 1 || i == 2) ? 8'h59 : 8'h99;
    bcd_field #(.MAX(LMAX)) u_fld (
      .val  (cur[i]),
      .down (dir_q),
      .en   (carry[i]),
      .nxt  (cnt_nxt[i])
    );
    if (i < NUM_FIELDS - 1) begin : g_cy
      assign carry[i+1] = carry[i] & (dir_q ? (cur[i] == 8'h00) : (cur[i] == LMAX));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      presc     <= '0;
      dir_q     <= 1'b0;
      time_data <= '0;
      running   <= 1'b0;
      expired   <= 1'b0;
      tick      <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clear) begin
        time_data <= '0;
        presc     <= '0;
        state     <= IDLE;
        running   <= 1'b0;
        expired   <= 1'b0;
      end else if (load && state != RUN && preset_ok) begin
        time_data <= preset_data;
        presc     <= '0;
        state     <= IDLE;
        running   <= 1'b0;
        expired   <= 1'b0;
      end else begin
        if (start_stop) begin
          case (state)
            IDLE, PAUSE: if (!(dir && at_zero)) begin
              state   <= RUN;
              running <= 1'b1;
              dir_q   <= dir;
            end
            RUN: begin
              state   <= PAUSE;
              running <= 1'b0;
            end
            default: ;
          endcase
        end
        // The edge that pauses still advances the prescaler, so a resume
        // waits exactly the remainder of the interrupted tick.
        if (state == RUN) begin
          if (fire) begin
            presc     <= '0;
            tick      <= 1'b1;
            time_data <= cnt_nxt;
            if (dir_q && cnt_nxt == '0) begin
              state   <= EXPIRED;
              running <= 1'b0;
              expired <= 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed + randomized bench for bcd_time_counter, checked every cycle against
// a model that keeps the time as a plain centisecond integer.

module tb_bcd_time_counter;
  localparam int DIVT  = 10;
  localparam int MAXCS = 36_000_000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_stop, clear, load, dir;
  logic [31:0] preset_data;
  logic [31:0] time_data;
  logic        running, expired, tick;

  int checks = 0;
  int errors = 0;

  bcd_time_counter #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear),
    .load(load), .dir(dir), .preset_data(preset_data),
    .time_data(time_data), .running(running), .expired(expired), .tick(tick)
  );

  always #5 clk = ~clk;

  // Model: 0 idle, 1 run, 2 pause, 3 expired
  int m_cs, m_p, m_st;
  bit m_dir, m_tick;

  function automatic logic [31:0] to_bcd(input int cs);
    int h, m, s, c;
    h = cs / 360000; m = (cs / 6000) % 60; s = (cs / 100) % 60; c = cs % 100;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic int dig(input logic [31:0] v, input int n);
    return int'(v[n*4 +: 4]);
  endfunction

  function automatic int from_bcd(input logic [31:0] v);
    return (dig(v,7)*10 + dig(v,6)) * 360000 + (dig(v,5)*10 + dig(v,4)) * 6000 +
           (dig(v,3)*10 + dig(v,2)) * 100 + dig(v,1)*10 + dig(v,0);
  endfunction

  function automatic bit bcd_ok(input logic [31:0] v);
    bit ok = (dig(v,5) <= 5) && (dig(v,3) <= 5);
    for (int n = 0; n < 8; n++) if (dig(v,n) > 9) ok = 0;
    return ok;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cs = 0; m_p = 0; m_st = 0; m_dir = 0; m_tick = 0;
  endtask

  task automatic model_edge();
    bit was_run;
    m_tick = 0;
    if (clear) begin
      m_cs = 0; m_p = 0; m_st = 0;
    end else if (load && m_st != 1 && bcd_ok(preset_data)) begin
      m_cs = from_bcd(preset_data); m_p = 0; m_st = 0;
    end else begin
      was_run = (m_st == 1);
      if (start_stop) begin
        if ((m_st == 0 || m_st == 2) && !(dir && m_cs == 0)) begin
          m_st = 1; m_dir = dir;
        end else if (m_st == 1) m_st = 2;
      end
      if (was_run) begin
        m_p++;
        if (m_p == DIVT) begin
          m_p = 0; m_tick = 1;
          m_cs = m_dir ? m_cs - 1 : (m_cs + 1) % MAXCS;
          if (m_dir && m_cs == 0) m_st = 3;
        end
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later,
  // then single-cycle pulses are dropped.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("time_data", time_data, to_bcd(m_cs));
    chk("running", {31'b0, running}, {31'b0, m_st == 1});
    chk("expired", {31'b0, expired}, {31'b0, m_st == 3});
    chk("tick", {31'b0, tick}, {31'b0, m_tick});
    start_stop = 0; clear = 0; load = 0;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int n, r;
    rst_n = 0; start_stop = 0; clear = 0; load = 0; dir = 0; preset_data = '0;
    model_reset();
    #2;
    chk("rst_time", time_data, 32'h0);
    chk("rst_flags", {29'b0, running, expired, tick}, 32'h0);
    #10 rst_n = 1;

    // Up count from zero
    clear = 1; step();
    dir = 0; start_stop = 1; step();
    steps(10);
    chk("up_10", time_data, 32'h00000001);
    steps(990);
    chk("up_1000", time_data, 32'h00000100);

    // Full wrap and hour carry
    start_stop = 1; step();
    load = 1; preset_data = 32'h99595999; step();
    start_stop = 1; step();
    steps(10);
    chk("wrap", time_data, 32'h00000000);
    chk("wrap_run", {31'b0, running}, 32'h1);
    start_stop = 1; step();
    load = 1; preset_data = 32'h00595999; step();
    start_stop = 1; step();
    steps(10);
    chk("hour_carry", time_data, 32'h01000000);

    // Countdown to expiry
    start_stop = 1; step();
    load = 1; preset_data = 32'h00000102; step();
    dir = 1; start_stop = 1; step();
    n = 0;
    while (!expired && n < 1100) begin step(); n++; end
    chk("expire_cycles", n, 1020);
    chk("expire_time", time_data, 32'h0);
    chk("expire_run", {31'b0, running}, 32'h0);
    for (int k = 0; k < 3; k++) begin start_stop = 1; step(); steps(4); end
    chk("expire_hold", {30'b0, running, expired}, 32'h1);

    // Pause preserves the partial tick
    clear = 1; step();
    dir = 0; start_stop = 1; step();
    steps(3);
    start_stop = 1; step();
    steps(50);
    start_stop = 1; step();
    n = 0;
    do begin step(); n++; end while (!tick && n < 20);
    chk("resume_gap", n, 6);

    // Priority and guards
    clear = 1; load = 1; start_stop = 1; preset_data = 32'h12345678; step();
    chk("prio_time", time_data, 32'h0);
    chk("prio_run", {31'b0, running}, 32'h0);
    load = 1; preset_data = 32'h00006000; step();
    chk("bad_load", time_data, 32'h0);
    load = 1; preset_data = 32'h00000500; step();
    start_stop = 1; step();
    steps(5);
    load = 1; preset_data = 32'h00001111; step();
    chk("run_load", time_data, 32'h00000500);
    clear = 1; step();
    dir = 1; start_stop = 1; step();
    chk("zero_down_start", {31'b0, running}, 32'h0);

    // Asynchronous reset mid-run
    dir = 0; start_stop = 1; step();
    steps(15);
    #2 rst_n = 0;
    #1;
    chk("arst_time", time_data, 32'h0);
    chk("arst_flags", {29'b0, running, expired, tick}, 32'h0);
    model_reset();
    #2 rst_n = 1;
    steps(20);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      dir = 1'($urandom_range(0, 1));
      if (r < 3) start_stop = 1;
      else if (r == 3) clear = 1;
      else if (r < 7) begin
        load = 1;
        preset_data = (r == 6) ? $urandom : to_bcd($urandom_range(0, 300));
      end
      if ($urandom_range(0, 9) == 0) begin
        start_stop = 1'($urandom_range(0, 1));
        clear = ($urandom_range(0, 7) == 0);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
